gerador_linhas: RTL and testbench

Sequential pattern generator for the 7-row LED matrix tank display. Runs the fill/empty animation state machine, advances a water level 0..7 on a divided time tick, and produces both row patterns (`linha_encher`, `linha_esvaziar`) plus the `sel` that picks between them. It is the source side of the row-selection mux: its three pattern/select outputs feed that mux directly, whose 7-bit output drives the matrix rows.

---
 rtl/gerador_linhas.sv | 119 +++++++++++
 tb/tb_gerador_linhas.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gerador_linhas.sv
// Fill/empty animation generator for the 7-row LED tank display: runs the
// tank FSM, steps a 0..7 water level on a divided tick and builds both row patterns.
module gerador_linhas #(
    parameter int DIV_TICK = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       encher,
    input  logic       esvaziar,
    output logic [6:0] linha_encher,
    output logic [6:0] linha_esvaziar,
    output logic       sel,
    output logic [2:0] nivel,
    output logic       cheio,
    output logic       vazio
);

    localparam int CNT_W = (DIV_TICK > 2) ? $clog2(DIV_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TICK - 1);

    typedef enum logic [1:0] {
        VAZIO,
        ENCHENDO,
        CHEIO,
        ESVAZIANDO
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [2:0]       nivel_q, nivel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    logic cmd_encher;
    logic cmd_esvaziar;
    logic tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= VAZIO;
            nivel_q  <= 3'd0;
            cnt_q    <= '0;
            blink_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            nivel_q  <= nivel_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
        end
    end

    always_comb begin
        // Both commands together cancel each other out.
        cmd_encher   = encher & ~esvaziar;
        cmd_esvaziar = esvaziar & ~encher;
        tick         = (cnt_q == CNT_LAST);

        estado_d = estado_q;
        nivel_d  = nivel_q;
        blink_d  = blink_q;
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);

        case (estado_q)
            VAZIO: begin
                if (cmd_encher) estado_d = ENCHENDO;
            end
            ENCHENDO: begin
                if (cmd_esvaziar) begin
                    estado_d = ESVAZIANDO;
                end else if (tick) begin
                    if (nivel_q >= 3'd6) begin
                        nivel_d  = 3'd7;
                        estado_d = CHEIO;
                    end else begin
                        nivel_d = nivel_q + 3'd1;
                    end
                end
            end
            CHEIO: begin
                if (cmd_esvaziar) estado_d = ESVAZIANDO;
            end
            ESVAZIANDO: begin
                if (cmd_encher) begin
                    estado_d = ENCHENDO;
                end else if (tick) begin
                    blink_d = ~blink_q;
                    if (nivel_q <= 3'd1) begin
                        nivel_d  = 3'd0;
                        estado_d = VAZIO;
                    end else begin
                        nivel_d = nivel_q - 3'd1;
                    end
                end
            end
            default: estado_d = VAZIO;
        endcase

        // Any transition restarts the step period so the first step is a full period away.
        if (estado_d != estado_q) cnt_d = '0;
        if ((estado_d != ESVAZIANDO) || (nivel_d == 3'd0)) blink_d = 1'b0;
    end

    logic [6:0] termo;
    logic [6:0] topo;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_linhas
            assign termo[gi] = (nivel_q > 3'(gi));
            assign topo[gi]  = (nivel_q == 3'(gi + 1));
        end
    endgenerate

    assign linha_encher   = termo;
    assign linha_esvaziar = termo ^ (topo & {7{blink_q}});
    assign sel            = (estado_q == ESVAZIANDO);
    assign nivel          = nivel_q;
    assign cheio          = (estado_q == CHEIO);
    assign vazio          = (estado_q == VAZIO);

endmodule

// File: tb/tb_gerador_linhas.sv
// Scoreboard bench for gerador_linhas with DIV_TICK=4: stimulus queues expected
// output snapshots, a monitor pops and compares them on the falling edge.
module tb_gerador_linhas;

    logic       clk = 1'b0;
    logic       reset;
    logic       encher;
    logic       esvaziar;
    logic [6:0] linha_encher;
    logic [6:0] linha_esvaziar;
    logic       sel;
    logic [2:0] nivel;
    logic       cheio;
    logic       vazio;

    gerador_linhas #(.DIV_TICK(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .encher         (encher),
        .esvaziar       (esvaziar),
        .linha_encher   (linha_encher),
        .linha_esvaziar (linha_esvaziar),
        .sel            (sel),
        .nivel          (nivel),
        .cheio          (cheio),
        .vazio          (vazio)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] nivel;
        logic       cheio;
        logic       vazio;
        logic       sel;
        logic [6:0] le;
        logic [6:0] lv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [6:0] therm(input int n);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string name, input int niv, input logic ch, input logic vz,
                              input logic s, input logic [6:0] le, input logic [6:0] lv);
        exp_t e;
        e.name  = name;
        e.nivel = 3'(niv);
        e.cheio = ch;
        e.vazio = vz;
        e.sel   = s;
        e.le    = le;
        e.lv    = lv;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued snapshot half a cycle after its edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (nivel !== e.nivel || cheio !== e.cheio || vazio !== e.vazio || sel !== e.sel ||
                linha_encher !== e.le || linha_esvaziar !== e.lv) begin
                errors++;
                $display("FAIL %s: got nivel=%0d cheio=%b vazio=%b sel=%b le=%b lv=%b, want nivel=%0d cheio=%b vazio=%b sel=%b le=%b lv=%b",
                         e.name, nivel, cheio, vazio, sel, linha_encher, linha_esvaziar,
                         e.nivel, e.cheio, e.vazio, e.sel, e.le, e.lv);
            end else begin
                $display("ok   %s: nivel=%0d cheio=%b vazio=%b sel=%b le=%b lv=%b",
                         e.name, nivel, cheio, vazio, sel, linha_encher, linha_esvaziar);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        encher   = 1'b0;
        esvaziar = 1'b0;
        step(2);
        expect_out("reset", 0, 0, 1, 0, 7'b0000000, 7'b0000000);
        reset = 1'b0;

        // Fill from VAZIO with a one-cycle encher pulse.
        encher = 1'b1;
        step(1);
        encher = 1'b0;
        expect_out("fill_entry", 0, 0, 0, 0, 7'b0000000, 7'b0000000);
        for (int k = 1; k <= 7; k++) begin
            step(3);
            expect_out($sformatf("fill_pre%0d", k), k - 1, 0, 0, 0, therm(k - 1), therm(k - 1));
            step(1);
            expect_out($sformatf("fill_lvl%0d", k), k, (k == 7), 0, 0, therm(k), therm(k));
        end
        expect_out("full_pattern", 7, 1, 0, 0, 7'b1111111, 7'b1111111);

        // CHEIO ignores encher alone and both commands together.
        encher = 1'b1;
        step(2);
        expect_out("cheio_encher_ign", 7, 1, 0, 0, 7'b1111111, 7'b1111111);
        esvaziar = 1'b1;
        step(2);
        expect_out("cheio_both_ign", 7, 1, 0, 0, 7'b1111111, 7'b1111111);
        encher = 1'b0;

        // Hold esvaziar: drain to VAZIO, blink toggling on each step.
        step(1);
        expect_out("drain_entry", 7, 0, 0, 1, 7'b1111111, 7'b1111111);
        step(4); expect_out("drain6", 6, 0, 0, 1, 7'b0111111, 7'b0011111);
        step(4); expect_out("drain5", 5, 0, 0, 1, 7'b0011111, 7'b0011111);
        step(4); expect_out("drain4", 4, 0, 0, 1, 7'b0001111, 7'b0000111);
        step(4); expect_out("drain3", 3, 0, 0, 1, 7'b0000111, 7'b0000111);
        step(4); expect_out("drain2", 2, 0, 0, 1, 7'b0000011, 7'b0000001);
        step(4); expect_out("drain1", 1, 0, 0, 1, 7'b0000001, 7'b0000001);
        step(4); expect_out("drain0", 0, 0, 1, 0, 7'b0000000, 7'b0000000);
        step(3); expect_out("vazio_esv_ign", 0, 0, 1, 0, 7'b0000000, 7'b0000000);
        esvaziar = 1'b0;

        // Reversal on the tick cycle: the command wins and the counter restarts.
        encher = 1'b1;
        step(1);
        encher = 1'b0;
        step(12);
        expect_out("rev_lvl3", 3, 0, 0, 0, 7'b0000111, 7'b0000111);
        step(3);
        esvaziar = 1'b1;
        step(1);
        esvaziar = 1'b0;
        expect_out("rev_on_tick", 3, 0, 0, 1, 7'b0000111, 7'b0000111);
        step(3); expect_out("rev_hold", 3, 0, 0, 1, 7'b0000111, 7'b0000111);
        step(1); expect_out("rev_dec", 2, 0, 0, 1, 7'b0000011, 7'b0000001);
        encher = 1'b1;
        step(1);
        encher = 1'b0;
        expect_out("rev_back_fill", 2, 0, 0, 0, 7'b0000011, 7'b0000011);

        // Reset mid-fill at level 4, with encher still asserted.
        step(8);
        expect_out("pre_reset_lvl4", 4, 0, 0, 0, 7'b0001111, 7'b0001111);
        reset  = 1'b1;
        encher = 1'b1;
        step(1);
        expect_out("mid_reset", 0, 0, 1, 0, 7'b0000000, 7'b0000000);
        reset    = 1'b0;
        esvaziar = 1'b1;
        step(2);
        expect_out("vazio_both_ign", 0, 0, 1, 0, 7'b0000000, 7'b0000000);
        encher   = 1'b0;
        esvaziar = 1'b0;

        // Saturation: reverse into ENCHENDO at level 7, next tick stays at 7.
        encher = 1'b1;
        step(1);
        encher = 1'b0;
        step(28);
        expect_out("refill_full", 7, 1, 0, 0, 7'b1111111, 7'b1111111);
        esvaziar = 1'b1;
        step(1);
        esvaziar = 1'b0;
        encher   = 1'b1;
        step(1);
        encher = 1'b0;
        expect_out("fill_at7", 7, 0, 0, 0, 7'b1111111, 7'b1111111);
        step(4);
        expect_out("sat7", 7, 1, 0, 0, 7'b1111111, 7'b1111111);

        step(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
